ram_controller: RTL
===================

# ram_controller

Circular sample buffer and readout engine for one ADC channel. It sits directly downstream of the trigger block. While the trigger block's write-enable is high, it stores ADC samples into a synchronous-read RAM. On a host request it streams the last `num_samples` stored samples, oldest first, to the Tx protocol using the rdy/eof/ack handshake. One instance is used per channel.

## Interface
- `RAM_AW`, 12, RAM address width; depth `DEPTH` = 2^RAM_AW samples.
- `BITS_ADC`, 8, sample width; must be ≤ 8.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  write enable from the trigger block (buffer controller).
- `adc_rdy`  in  1  one-cycle strobe marking a valid `adc_data`.
- `adc_data`  in  BITS_ADC  ADC sample.
- `num_samples`  in  16  samples to return, taken from the NUM_SAMPLES_H/L registers.
- `rqst_data`  in  1  one-cycle readout request from the request handler.
- `tx_data`  out  8  sample being sent, zero-extended to 8 bits.
- `tx_rdy`  out  1  `tx_data` is valid.
- `tx_eof`  out  1  current byte is the last of the frame.
- `tx_ack`  in  1  Tx protocol has accepted the byte.
- `busy`  out  1  readout in progress.

## Operation
- **Storage**
  - Single-port-write, registered-read RAM: `mem[DEPTH]`.
  - Write pointer `wr_ptr` is RAM_AW bits.
- **Write rule**
  - Writes happen only when `we & adc_rdy & (state==IDLE)`: `mem[wr_ptr] <= adc_data`, then `wr_ptr <= wr_ptr+1`.
  - `wr_ptr` wraps modulo DEPTH with no full flag; the oldest data is overwritten.
- **Readout length**
  - On `rqst_data` in IDLE: `n = min(num_samples, DEPTH)`, stored in a 17-bit counter `remaining`.
  - Start address: `rd_ptr = wr_ptr - n` (mod DEPTH), i.e. the oldest of the last n writes.
  - If `n == 0`, the request is ignored and the block stays in IDLE with no output.
- **State machine**
  - IDLE: on `rqst_data` with `n > 0`, go to FETCH.
  - FETCH: present `rd_ptr` to the RAM. Next state is VALID.
  - VALID: `tx_data` holds the RAM output (registered), `tx_rdy` = 1, and `tx_eof` = 1 when `remaining == 1`.
  - On `tx_ack` in VALID: `rd_ptr <= rd_ptr+1` (wraps), `remaining <= remaining-1`. Go to IDLE if `remaining == 1`, otherwise go to FETCH.
  - `tx_ack` outside VALID is ignored.
- **Other rules**
  - `busy` = 1 in FETCH and VALID.
  - `rqst_data` while busy is ignored; it is neither queued nor restarts the readout.
  - Writes are blocked while busy, so the frame is always consistent even if `we` is still high.
  - Samples presented during readout are dropped and do not advance `wr_ptr`.
  - `tx_data` is held stable from `tx_rdy` rise until the cycle after `tx_ack`.
  - `num_samples` is sampled only at request time; later changes do not affect the frame in flight.

## Timing
- **Reset values**
  - state = IDLE, `wr_ptr` = 0, `rd_ptr` = 0, `remaining` = 0.
  - `tx_rdy` = 0, `tx_eof` = 0, `tx_data` = 0, `busy` = 0.
  - RAM contents are not cleared.
- **Reset mid-operation**
  - Readout aborts immediately. `tx_rdy` is 0 in the cycle after reset is sampled.
  - `wr_ptr` returns to 0.
- **Write path**
  - Sample written at edge k is readable by a request at edge k+1 or later.
- **Readout latency**
  - `rqst_data` sampled at edge k: FETCH in cycle k+1, `tx_rdy` high in cycle k+2.
- **Handshake**
  - `tx_ack` high at edge m while `tx_rdy` is high: `tx_rdy` is low in cycle m+1, and the next `tx_rdy` is high in cycle m+2.
  - Peak throughput is 1 byte per 2 cycles.
  - `tx_eof` changes only together with `tx_rdy` and is never high while `tx_rdy` is low.
- **Simultaneous events**
  - `rqst_data` together with a qualifying write in the same IDLE cycle: the write completes first, and `rd_ptr` is computed from the post-write `wr_ptr`, so the new sample is included.
  - `tx_ack` held high continuously: the block advances one byte every 2 cycles.

## Test plan
- **Basic readout:** reset; write 0x10..0x17 (8 samples) with `we` = 1; `num_samples` = 4; pulse `rqst_data` → bytes 0x14, 0x15, 0x16, 0x17; `tx_eof` only on 0x17; `busy` drops after the last ack.
- **Wrap-around:** RAM_AW = 4; write 20 samples with values 0..19; `num_samples` = 16 → output 4..19 in order. Then `num_samples` = 40 → clamps to 16 and gives the same 16 bytes.
- **Backpressure:** hold `tx_ack` low for 10 cycles in VALID → `tx_rdy` and `tx_data` stay constant; ack once → exactly one byte consumed, next `tx_rdy` 2 cycles later.
- **Write blocking and ignored request:** during a readout drive `we` = 1 with 5 `adc_rdy` strobes and a second `rqst_data` → `wr_ptr` unchanged, frame length unchanged, no second frame.
- **Zero length and same-cycle write:** `num_samples` = 0 plus `rqst_data` → no `tx_rdy`, `busy` stays 0. `rqst_data` in the same cycle as a write of 0xAA with `num_samples` = 1 → output 0xAA with `tx_eof` = 1.
- **Reset mid-frame:** assert `rst` after 2 of 6 bytes → `tx_rdy` = 0 and `busy` = 0 next cycle; after new writes 0x01, 0x02 and `num_samples` = 2 → output 0x01, 0x02.

Source files
------------

// File: rtl/ram_controller.sv
// ram_controller: circular ADC sample buffer that replays the last num_samples samples, oldest first,
// over the rdy/eof/ack byte handshake.
module ram_controller #(
   parameter int RAM_AW   = 12,
   parameter int BITS_ADC = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic                adc_rdy,
   input  logic [BITS_ADC-1:0] adc_data,
   input  logic [15:0]         num_samples,
   input  logic                rqst_data,
   output logic [7:0]          tx_data,
   output logic                tx_rdy,
   output logic                tx_eof,
   input  logic                tx_ack,
   output logic                busy
);
   localparam int DEPTH = 1 << RAM_AW;
   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
   state_t              state_q;
   logic [BITS_ADC-1:0] mem [DEPTH];
   logic [BITS_ADC-1:0] ram_q;
   logic [RAM_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q;
   logic [16:0]         remaining_q, n_d;
   logic                wr_en, tx_rdy_q, tx_eof_q, busy_q;
   always_comb begin
      wr_en    = we & adc_rdy & (state_q == IDLE);
      wr_ptr_d = wr_ptr_q + RAM_AW'(wr_en);
      n_d      = ({1'b0, num_samples} > 17'(DEPTH)) ? 17'(DEPTH) : {1'b0, num_samples};
   end
   // Read port is free-running; rd_ptr only moves outside VALID, so the byte stays put while offered.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= adc_data;
      ram_q <= mem[rd_ptr_q];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         remaining_q <= '0;
         tx_rdy_q    <= 1'b0;
         tx_eof_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               wr_ptr_q <= wr_ptr_d;
               // Start from the post-write pointer so a same-cycle sample is part of the frame.
               if (rqst_data && n_d != '0) begin
                  rd_ptr_q    <= wr_ptr_d - n_d[RAM_AW-1:0];
                  remaining_q <= n_d;
                  busy_q      <= 1'b1;
                  state_q     <= FETCH;
               end
            end
            FETCH: begin
               tx_rdy_q <= 1'b1;
               tx_eof_q <= remaining_q == 17'd1;
               state_q  <= VALID;
            end
            VALID: if (tx_ack) begin
               rd_ptr_q    <= rd_ptr_q + 1'b1;
               remaining_q <= remaining_q - 17'd1;
               tx_rdy_q    <= 1'b0;
               tx_eof_q    <= 1'b0;
               busy_q      <= remaining_q != 17'd1;
               state_q     <= (remaining_q == 17'd1) ? IDLE : FETCH;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign tx_data = tx_rdy_q ? 8'(ram_q) : 8'h00;
   assign tx_rdy  = tx_rdy_q;
   assign tx_eof  = tx_eof_q;
   assign busy    = busy_q;
endmodule
